mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter_pkg.sv | 25 ++
 rtl/mem_arbiter_if.sv | 58 +++++
 rtl/mem_arbiter_fairness.sv | 51 +++++
 rtl/mem_arbiter.sv | 121 ++++++++++++
 tb/tb_mem_arbiter.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// arm_mem_pkg
// Shared types and defaults for the instruction/data memory arbiter.
//   arb_state_e : arbiter FSM states (IDLE = arbitrate/issue, RESP = respond)
//   arb_owner_e : which core port owns the access in flight
//   ADDR_W_DEF / DATA_W_DEF : default bus widths
//   STREAK_W    : width of the data-grant streak counter
// ---------------------------------------------------------------------------
package arm_mem_pkg;

   localparam int unsigned ADDR_W_DEF = 32;
   localparam int unsigned DATA_W_DEF = 32;
   localparam int unsigned STREAK_W   = 4;

   typedef enum logic {
      IDLE = 1'b0,
      RESP = 1'b1
   } arb_state_e;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_D  = 1'b1
   } arb_owner_e;

endpackage : arm_mem_pkg

// File: rtl/mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_arbiter_if
// Bundles the core-side fetch/data ports and the RAM-side port of the
// arbiter.
//   Fetch : if_req, if_addr          -> if_rdata, if_ready
//   Data  : d_req, d_we, d_addr, d_wdata -> d_rdata, d_ready
//   RAM   : mem_en, mem_we, mem_addr, mem_wdata -> mem_rdata
// Modports:
//   slave  : the arbiter's view
//   master : the environment's view (core requesters + RAM)
// ---------------------------------------------------------------------------
interface mem_arbiter_if
   import arm_mem_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF
);

   // fetch port
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic [DATA_W-1:0] if_rdata;
   logic              if_ready;

   // data port
   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic [DATA_W-1:0] d_rdata;
   logic              d_ready;

   // unified RAM port
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  if_req, if_addr,
      output if_rdata, if_ready,
      input  d_req, d_we, d_addr, d_wdata,
      output d_rdata, d_ready,
      output mem_en, mem_we, mem_addr, mem_wdata,
      input  mem_rdata
   );

   modport master (
      output if_req, if_addr,
      input  if_rdata, if_ready,
      output d_req, d_we, d_addr, d_wdata,
      input  d_rdata, d_ready,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      output mem_rdata
   );

endinterface : mem_arbiter_if

// File: rtl/mem_arbiter_fairness.sv
// ---------------------------------------------------------------------------
// mem_arb_fairness
// Counts consecutive data grants issued while a fetch is waiting and raises
// force_if once D_STREAK_MAX of them have gone by, so fetch cannot starve.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   grant_d     : a data access is being issued this cycle
//   grant_if    : a fetch access is being issued this cycle
//   if_pending  : fetch request is asserted this cycle
//   force_if    : streak has reached D_STREAK_MAX
// ---------------------------------------------------------------------------
module mem_arb_fairness
   import arm_mem_pkg::*;
#(
   parameter int unsigned D_STREAK_MAX = 4   // legal 1..15
) (
   input  logic clk,
   input  logic reset,
   input  logic grant_d,
   input  logic grant_if,
   input  logic if_pending,
   output logic force_if
);

   localparam logic [STREAK_W-1:0] STREAK_LIMIT = STREAK_W'(D_STREAK_MAX);

   logic [STREAK_W-1:0] r_streak;

   // NOTE: state registers use non-blocking assignments so every flop in the
   // design samples the pre-edge value of its inputs, independent of the
   // order the simulator evaluates always blocks.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_streak <= '0;
      end else if (grant_if) begin
         r_streak <= '0;
      end else if (grant_d) begin
         if (!if_pending) begin
            // nobody was kept waiting, so the streak is not "unfair"
            r_streak <= '0;
         end else if (r_streak != STREAK_LIMIT) begin
            // the saturation guard is belt-and-braces: at the limit the
            // arbiter hands the slot to fetch instead
            r_streak <= r_streak + 1'b1;
         end
      end
   end

   assign force_if = (r_streak == STREAK_LIMIT);

endmodule : mem_arb_fairness

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Shares one single-port synchronous RAM between the core's instruction
// fetch port and its data (MEM-stage) port. Data wins by default; the
// fairness sub-block forces a fetch grant after D_STREAK_MAX consecutive
// data grants with a fetch waiting.
//
// Each access takes two cycles: IDLE issues the winner to the RAM
// combinationally, RESP forwards mem_rdata and pulses the owner's ready.
//
// Ports:
//   clk    : system clock, rising edge
//   reset  : synchronous, active-high; forces all outputs to 0 while high
//   bus    : mem_arbiter_if.slave (fetch port, data port, RAM port)
// ---------------------------------------------------------------------------
module mem_arbiter
   import arm_mem_pkg::*;
#(
   parameter int unsigned ADDR_W       = ADDR_W_DEF,
   parameter int unsigned DATA_W       = DATA_W_DEF,
   parameter int unsigned D_STREAK_MAX = 4
) (
   input  logic          clk,
   input  logic          reset,
   mem_arbiter_if.slave  bus
);

   arb_state_e r_state;
   arb_owner_e r_owner;

   logic              w_idle;
   logic              w_force_if;
   logic              w_grant_d;
   logic              w_grant_if;
   logic              w_mem_en;
   logic              w_mem_we;
   logic [ADDR_W-1:0] w_mem_addr;
   logic [DATA_W-1:0] w_mem_wdata;
   logic              w_resp;

   // arbitration only happens in IDLE, and never while reset is held
   assign w_idle     = (r_state == IDLE) && !reset;
   assign w_grant_d  = w_idle && bus.d_req && (!bus.if_req || !w_force_if);
   assign w_grant_if = w_idle && bus.if_req && !w_grant_d;
   assign w_resp     = (r_state == RESP) && !reset;

   mem_arb_fairness #(
      .D_STREAK_MAX (D_STREAK_MAX)
   ) u_fairness (
      .clk        (clk),
      .reset      (reset),
      .grant_d    (w_grant_d),
      .grant_if   (w_grant_if),
      .if_pending (bus.if_req),
      .force_if   (w_force_if)
   );

   // FSM: latch the owner on a grant, respond for one cycle, back to IDLE.
   // A requester dropping req during RESP has no effect here: the owner is
   // already latched and the response is issued regardless.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_owner <= OWN_IF;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_grant_d || w_grant_if) begin
                  r_owner <= w_grant_d ? OWN_D : OWN_IF;
                  r_state <= RESP;
               end
            end
            RESP:    r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   // RAM request mux: the winner drives the RAM in the same IDLE cycle
   // NOTE: every signal written in an always_comb gets a default at the top
   // of the block; without it some path leaves it unassigned and a latch is
   // inferred.
   always_comb begin
      w_mem_en    = 1'b0;
      w_mem_we    = 1'b0;
      w_mem_addr  = '0;
      w_mem_wdata = '0;
      if (w_grant_d) begin
         w_mem_en    = 1'b1;
         w_mem_we    = bus.d_we;
         w_mem_addr  = bus.d_addr;
         w_mem_wdata = bus.d_wdata;
      end else if (w_grant_if) begin
         w_mem_en    = 1'b1;
         w_mem_addr  = bus.if_addr;
      end
   end

   assign bus.mem_en    = w_mem_en;
   assign bus.mem_we    = w_mem_we;
   assign bus.mem_addr  = w_mem_addr;
   assign bus.mem_wdata = w_mem_wdata;

   // Response: only the latched owner sees ready/rdata; the other port reads 0
   always_comb begin
      bus.if_ready = 1'b0;
      bus.if_rdata = '0;
      bus.d_ready  = 1'b0;
      bus.d_rdata  = '0;
      if (w_resp) begin
         if (r_owner == OWN_D) begin
            bus.d_ready = 1'b1;
            bus.d_rdata = bus.mem_rdata;
         end else begin
            bus.if_ready = 1'b1;
            bus.if_rdata = bus.mem_rdata;
         end
      end
   end

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
// Directed bench for mem_arbiter with a behavioural synchronous RAM.
// Expected read results are queued per port when a request is driven and
// popped by a negedge monitor when that port's ready pulses.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

   localparam logic [31:0] FETCH_ADDR = 32'h0000_0010;
   localparam logic [31:0] FETCH_WORD = 32'hE3A0_0005;
   localparam logic [31:0] DATA_ADDR  = 32'h0000_0064;
   localparam logic [31:0] DATA_WORD  = 32'hDEAD_BEEF;

   typedef struct {
      logic        chk;    // 0 = write response, content is don't-care
      logic [31:0] data;
   } exp_t;

   logic clk;
   logic reset;

   mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   mem_arbiter #(
      .ADDR_W       (32),
      .DATA_W       (32),
      .D_STREAK_MAX (4)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc_cnt = 0;
   exp_t q_if[$];
   exp_t q_d[$];
   exp_t mon_e;

   logic [31:0] ram [0:255];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   // Behavioural RAM: read data valid the cycle after mem_en
   always @(posedge clk) begin
      if (reset) begin
         ram[FETCH_ADDR[9:2]] <= FETCH_WORD;
      end else if (bus.mem_en) begin
         if (bus.mem_we) ram[bus.mem_addr[9:2]] <= bus.mem_wdata;
         else            bus.mem_rdata <= ram[bus.mem_addr[9:2]];
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_tests++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
      end
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      if (!reset) begin
         if (bus.if_ready && bus.d_ready) check("dual_ready", 32'(bus.d_ready), 32'd0);
         if (bus.if_ready) begin
            if (q_if.size() == 0) begin
               check("if_ready_unexpected", 32'(bus.if_ready), 32'd0);
            end else begin
               mon_e = q_if.pop_front();
               if (mon_e.chk) check("if_rdata", bus.if_rdata, mon_e.data);
            end
         end else begin
            check("if_rdata_idle_zero", bus.if_rdata, 32'd0);
         end
         if (bus.d_ready) begin
            if (q_d.size() == 0) begin
               check("d_ready_unexpected", 32'(bus.d_ready), 32'd0);
            end else begin
               mon_e = q_d.pop_front();
               if (mon_e.chk) check("d_rdata", bus.d_rdata, mon_e.data);
            end
         end else begin
            check("d_rdata_idle_zero", bus.d_rdata, 32'd0);
         end
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // One read access, entered at the start of an IDLE cycle; returns at the
   // start of the following IDLE cycle.
   task automatic run_access(input bit if_on, input bit d_on, input bit exp_d);
      bus.if_req  = if_on;
      bus.if_addr = FETCH_ADDR;
      bus.d_req   = d_on;
      bus.d_we    = 1'b0;
      bus.d_addr  = DATA_ADDR;
      if (exp_d) q_d.push_back('{chk: 1'b1, data: DATA_WORD});
      else       q_if.push_back('{chk: 1'b1, data: FETCH_WORD});
      @(negedge clk);
      check("arb_mem_en", 32'(bus.mem_en), 32'd1);
      check(exp_d ? "arb_addr_d" : "arb_addr_if", bus.mem_addr, exp_d ? DATA_ADDR : FETCH_ADDR);
      next_cycle();
      @(negedge clk);
      check(exp_d ? "arb_d_ready" : "arb_if_ready",
            32'(exp_d ? bus.d_ready : bus.if_ready), 32'd1);
      check("arb_resp_mem_en", 32'(bus.mem_en), 32'd0);
      next_cycle();
   endtask

   // Timeout guard
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "time limit reached");
   end

   initial begin
      bit contend_d [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
      bit clr_if_on [9]  = '{1, 1, 1, 0, 1, 1, 1, 1, 1};
      bit clr_d     [9]  = '{1, 1, 1, 1, 1, 1, 1, 1, 0};
      int t0, t1;

      reset         = 1'b1;
      bus.if_req    = 1'b0;
      bus.if_addr   = '0;
      bus.d_req     = 1'b0;
      bus.d_we      = 1'b0;
      bus.d_addr    = '0;
      bus.d_wdata   = '0;
      bus.mem_rdata = '0;

      // ---- reset state ----
      @(posedge clk);
      @(negedge clk);
      check("rst_mem_en",   32'(bus.mem_en),   32'd0);
      check("rst_mem_addr", bus.mem_addr,      32'd0);
      check("rst_if_ready", 32'(bus.if_ready), 32'd0);
      check("rst_d_ready",  32'(bus.d_ready),  32'd0);
      next_cycle();
      reset = 1'b0;
      @(negedge clk);
      check("idle_no_req_mem_en", 32'(bus.mem_en), 32'd0);
      next_cycle();

      // ---- single fetch ----
      bus.if_req  = 1'b1;
      bus.if_addr = FETCH_ADDR;
      q_if.push_back('{chk: 1'b1, data: FETCH_WORD});
      @(negedge clk);
      check("fetch_mem_en",   32'(bus.mem_en),  32'd1);
      check("fetch_mem_addr", bus.mem_addr,     FETCH_ADDR);
      check("fetch_mem_we",   32'(bus.mem_we),  32'd0);
      check("fetch_d_ready0", 32'(bus.d_ready), 32'd0);
      next_cycle();
      @(negedge clk);
      check("fetch_if_ready", 32'(bus.if_ready), 32'd1);
      check("fetch_d_ready1", 32'(bus.d_ready),  32'd0);
      next_cycle();
      bus.if_req = 1'b0;
      @(negedge clk);
      check("fetch_after_mem_en", 32'(bus.mem_en),   32'd0);
      check("fetch_after_ready",  32'(bus.if_ready), 32'd0);
      next_cycle();

      // ---- data write then read ----
      bus.d_req   = 1'b1;
      bus.d_we    = 1'b1;
      bus.d_addr  = DATA_ADDR;
      bus.d_wdata = DATA_WORD;
      q_d.push_back('{chk: 1'b0, data: 32'd0});
      @(negedge clk);
      check("wr_mem_en",    32'(bus.mem_en), 32'd1);
      check("wr_mem_we",    32'(bus.mem_we), 32'd1);
      check("wr_mem_addr",  bus.mem_addr,    DATA_ADDR);
      check("wr_mem_wdata", bus.mem_wdata,   DATA_WORD);
      next_cycle();
      @(negedge clk);
      check("wr_d_ready",    32'(bus.d_ready), 32'd1);
      check("wr_resp_we",    32'(bus.mem_we),  32'd0);
      t0 = cyc_cnt;
      next_cycle();
      bus.d_we    = 1'b0;
      bus.d_wdata = '0;
      q_d.push_back('{chk: 1'b1, data: DATA_WORD});
      @(negedge clk);
      check("rd_mem_en", 32'(bus.mem_en), 32'd1);
      check("rd_mem_we", 32'(bus.mem_we), 32'd0);
      next_cycle();
      @(negedge clk);
      check("rd_d_ready", 32'(bus.d_ready), 32'd1);
      t1 = cyc_cnt;
      check("d_ready_spacing", 32'(t1 - t0), 32'd2);
      next_cycle();
      bus.d_req = 1'b0;

      // ---- contention: D,D,D,D,I repeating ----
      for (int i = 0; i < 10; i++) run_access(1'b1, 1'b1, contend_d[i]);

      // ---- streak clear: fetch absent for one data grant ----
      for (int i = 0; i < 9; i++) begin
         run_access(clr_if_on[i], 1'b1, clr_d[i]);
         if (i == 3) check("streak_cleared", 32'(dut.u_fairness.r_streak), 32'd0);
      end
      bus.if_req = 1'b0;
      bus.d_req  = 1'b0;

      // ---- reset during RESP of a read ----
      bus.d_req  = 1'b1;
      bus.d_we   = 1'b0;
      bus.d_addr = DATA_ADDR;
      @(negedge clk);
      check("rstresp_issue_en", 32'(bus.mem_en), 32'd1);
      next_cycle();
      reset = 1'b1;
      @(negedge clk);
      check("rstresp_d_ready",  32'(bus.d_ready),  32'd0);
      check("rstresp_d_rdata",  bus.d_rdata,       32'd0);
      check("rstresp_if_ready", 32'(bus.if_ready), 32'd0);
      check("rstresp_mem_en",   32'(bus.mem_en),   32'd0);
      check("rstresp_mem_addr", bus.mem_addr,      32'd0);
      next_cycle();
      reset     = 1'b0;
      bus.d_req = 1'b0;
      @(negedge clk);
      check("postrst_d_ready", 32'(bus.d_ready), 32'd0);
      check("postrst_mem_en",  32'(bus.mem_en),  32'd0);
      next_cycle();
      bus.d_req = 1'b1;
      q_d.push_back('{chk: 1'b1, data: DATA_WORD});
      @(negedge clk);
      check("postrst_issue_en", 32'(bus.mem_en), 32'd1);
      next_cycle();
      @(negedge clk);
      check("postrst_ready", 32'(bus.d_ready), 32'd1);
      next_cycle();
      bus.d_req = 1'b0;
      next_cycle();

      // ---- early drop of d_req during RESP ----
      bus.d_req = 1'b1;
      q_d.push_back('{chk: 1'b1, data: DATA_WORD});
      @(negedge clk);
      check("drop_issue_en", 32'(bus.mem_en), 32'd1);
      next_cycle();
      bus.d_req = 1'b0;
      @(negedge clk);
      check("drop_d_ready", 32'(bus.d_ready), 32'd1);
      next_cycle();
      @(negedge clk);
      check("drop_idle_en",    32'(bus.mem_en),  32'd0);
      check("drop_idle_ready", 32'(bus.d_ready), 32'd0);
      next_cycle();
      @(negedge clk);
      check("drop_idle2_en", 32'(bus.mem_en), 32'd0);

      // ---- every queued response must have been delivered ----
      check("q_if_drained", 32'(q_if.size()), 32'd0);
      check("q_d_drained",  32'(q_d.size()),  32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_mem_arbiter
